median_window_feeder: RTL and testbench

Streaming front end for the 3-input median stage: accepts a frame of 4-bit samples over a valid/ready handshake, maintains a 3-sample sliding window and presents each window as a registered triple (num1, num2, num3) to the median finder. It sits directly upstream of the median stage. It owns all sequencing, including:
- frame start and end handling
- edge replication
- backpressure

---
 rtl/median_pkg.sv | 20 ++
 rtl/window_reg3.sv | 42 ++++
 rtl/median_window_feeder.sv | 132 +++++++++++++
 tb/tb_median_window_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types for the median window feeder: sample width, FSM states
// and the window triple handed to the median stage.
package median_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ONE   = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] num1;
      logic [DATA_W-1:0] num2;
      logic [DATA_W-1:0] num3;
   } win_t;

endpackage

// File: rtl/window_reg3.sv
// Holds the two previous samples of the current frame (w0 oldest, w1 newest).
// load_en writes w1 only; shift_en moves w1 into w0 and writes w1.
import median_pkg::*;

module window_reg3 (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en_i,
   input  logic              shift_en_i,
   input  logic [DATA_W-1:0] x_i,
   output logic [DATA_W-1:0] w0_o,
   output logic [DATA_W-1:0] w1_o
);

   logic [DATA_W-1:0] w0_q, w0_d;
   logic [DATA_W-1:0] w1_q, w1_d;

   always_comb begin
      w0_d = w0_q;
      w1_d = w1_q;
      if (shift_en_i) begin
         w0_d = w1_q;
         w1_d = x_i;
      end else if (load_en_i) begin
         w1_d = x_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w0_q <= '0;
         w1_q <= '0;
      end else begin
         w0_q <= w0_d;
         w1_q <= w1_d;
      end
   end

   assign w0_o = w0_q;
   assign w1_o = w1_q;

endmodule

// File: rtl/median_window_feeder.sv
// Streaming 3-sample window feeder for the median stage.
// Define MEDIAN_EDGE_REPLICATE_EN to replicate frame edges (N windows per frame).
import median_pkg::*;

module median_window_feeder (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_num1,
   output logic [DATA_W-1:0] out_num2,
   output logic [DATA_W-1:0] out_num3,
   output logic              out_last
);

   state_e            state_q, state_d;
   win_t              win_q, win_d;
   logic              vld_q;
   logic              last_q, last_d;
   logic              ld;
   logic              load_en, shift_en;
   logic              free, acc;
   logic [DATA_W-1:0] w0, w1;

   assign free     = !vld_q || out_ready;
   assign in_ready = !rst && (state_q != FLUSH) && free;
   assign acc      = in_valid && in_ready;

   window_reg3 u_win (
      .clk        (clk),
      .rst        (rst),
      .load_en_i  (load_en),
      .shift_en_i (shift_en),
      .x_i        (in_data),
      .w0_o       (w0),
      .w1_o       (w1)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = '0;
      last_d   = 1'b0;
      ld       = 1'b0;
      load_en  = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               load_en = 1'b1;
               if (in_last) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
                  ld     = 1'b1;
                  win_d  = '{in_data, in_data, in_data};
                  last_d = 1'b1;
`endif
                  state_d = IDLE;
               end else begin
                  state_d = ONE;
               end
            end
         end
         ONE: begin
            if (acc) begin
               shift_en = 1'b1;
               state_d  = in_last ? IDLE : RUN;
`ifdef MEDIAN_EDGE_REPLICATE_EN
               ld    = 1'b1;
               win_d = '{w1, w1, in_data};
               if (in_last) state_d = FLUSH;
`endif
            end
         end
         RUN: begin
            if (acc) begin
               shift_en = 1'b1;
               ld       = 1'b1;
               win_d    = '{w0, w1, in_data};
`ifdef MEDIAN_EDGE_REPLICATE_EN
               state_d = in_last ? FLUSH : RUN;
`else
               last_d  = in_last;
               state_d = in_last ? IDLE : RUN;
`endif
            end
         end
         FLUSH: begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
            // Tail window: last sample replicated into num3
            if (free) begin
               ld      = 1'b1;
               win_d   = '{w0, w1, w1};
               last_d  = 1'b1;
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         win_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ld) begin
            vld_q  <= 1'b1;
            win_q  <= win_d;
            last_q <= last_d;
         end else if (out_ready) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
         end
      end
   end

   assign out_valid = vld_q;
   assign out_num1  = win_q.num1;
   assign out_num2  = win_q.num2;
   assign out_num3  = win_q.num3;
   assign out_last  = last_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench for median_window_feeder; expectations follow
// MEDIAN_EDGE_REPLICATE_EN when it is defined for the build.
module tb_median_window_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_num1, out_num2, out_num3;
   logic       out_last;

   int ncmp = 0;
   int nerr = 0;

   logic [12:0] q[$];
   logic        tog_en = 1'b0;
   logic [3:0]  pat = 4'b1001;
   int          ph = 0;
   logic        stalled = 1'b0;
   logic [12:0] held = '0;

   median_window_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num1  (out_num1),
      .out_num2  (out_num2),
      .out_num3  (out_num3),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // out_ready pattern 1,0,0,1 when toggling is enabled
   always @(posedge clk) begin
      #1;
      if (tog_en) begin
         out_ready = pat[3-ph];
         ph = (ph + 1) % 4;
      end
   end

   // Output monitor: scoreboard pop, stall stability, backpressure
   always @(negedge clk) begin
      logic [12:0] obs;
      obs = {out_num1, out_num2, out_num3, out_last};
      if (!rst) begin
         if (stalled && out_valid) begin
            ncmp++;
            assert (obs === held) else begin
               nerr++;
               $error("FAIL stall_hold got %h exp %h", obs, held);
            end
         end
         if (out_valid && !out_ready) begin
            ncmp++;
            assert (in_ready === 1'b0) else begin
               nerr++;
               $error("FAIL bp_in_ready got %b exp 0", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            ncmp++;
            assert (q.size() != 0) else begin
               nerr++;
               $error("FAIL unexpected_win got %h exp none", obs);
            end
            if (q.size() != 0) begin
               logic [12:0] e;
               e = q.pop_front();
               ncmp++;
               assert (obs === e) else begin
                  nerr++;
                  $error("FAIL window got %h exp %h", obs, e);
               end
            end
         end
         stalled = out_valid && !out_ready;
         held    = obs;
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic expw(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic l);
      q.push_back({a, b, c, l});
   endtask

   task automatic send(input logic [3:0] d, input logic l);
      bit ok;
      int n;
      ok = 1'b0;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!ok && n < 50) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      ncmp++;
      assert (ok) else begin
         nerr++;
         $error("FAIL send_timeout got 0 exp 1");
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      ncmp++;
      assert (q.size() == 0) else begin
         nerr++;
         $error("FAIL drain_%s got %0d exp 0", tag, q.size());
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      ncmp++;
      assert (in_ready === 1'b0) else begin
         nerr++;
         $error("FAIL rst_in_ready got %b exp 0", in_ready);
      end
      ncmp++;
      assert ({out_valid, out_last, out_num1, out_num2, out_num3} === 15'h0)
      else begin
         nerr++;
         $error("FAIL rst_outs got %h exp 0",
                {out_valid, out_last, out_num1, out_num2, out_num3});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      ncmp++;
      assert (in_ready === 1'b1) else begin
         nerr++;
         $error("FAIL post_rst_in_ready got %b exp 1", in_ready);
      end
      @(posedge clk);
      #1;

      // Frame 3,9,1,7
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h3, 4'h3, 4'h9, 1'b0);
`endif
      expw(4'h3, 4'h9, 4'h1, 1'b0);
      expw(4'h9, 4'h1, 4'h7, 1'b0);
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h1, 4'h7, 4'h7, 1'b1);
`else
      q[q.size()-1][0] = 1'b1;
`endif
      send(4'h3, 1'b0);
      send(4'h9, 1'b0);
      send(4'h1, 1'b0);
      send(4'h7, 1'b1);
      @(negedge clk);
      ncmp++;
`ifdef MEDIAN_EDGE_REPLICATE_EN
      assert (in_ready === 1'b0) else begin
         nerr++;
         $error("FAIL flush_in_ready got %b exp 0", in_ready);
      end
`else
      assert (in_ready === 1'b1) else begin
         nerr++;
         $error("FAIL idle_in_ready got %b exp 1", in_ready);
      end
`endif
      drain("frame1");

      // Single-sample frame
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h5, 4'h5, 4'h5, 1'b1);
`endif
      send(4'h5, 1'b1);
      drain("single");

      // Stalled frame 2,4,6,8,A
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h2, 4'h2, 4'h4, 1'b0);
`endif
      expw(4'h2, 4'h4, 4'h6, 1'b0);
      expw(4'h4, 4'h6, 4'h8, 1'b0);
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h6, 4'h8, 4'hA, 1'b0);
      expw(4'h8, 4'hA, 4'hA, 1'b1);
`else
      expw(4'h6, 4'h8, 4'hA, 1'b1);
`endif
      ph = 0;
      tog_en = 1'b1;
      send(4'h2, 1'b0);
      send(4'h4, 1'b0);
      send(4'h6, 1'b0);
      send(4'h8, 1'b0);
      send(4'hA, 1'b1);
      repeat (12) @(posedge clk);
      tog_en = 1'b0;
      #2;
      out_ready = 1'b1;
      drain("stall");

      // Reset mid-frame
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h4, 4'h4, 4'hF, 1'b0);
`endif
      send(4'h4, 1'b0);
      send(4'hF, 1'b0);
      drain("pre_rst");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ncmp++;
      assert (out_valid === 1'b0) else begin
         nerr++;
         $error("FAIL rst_mid_valid got %b exp 0", out_valid);
      end
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h1, 4'h1, 4'h2, 1'b0);
      expw(4'h1, 4'h2, 4'h3, 1'b0);
      expw(4'h2, 4'h3, 4'h3, 1'b1);
`else
      expw(4'h1, 4'h2, 4'h3, 1'b1);
`endif
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      send(4'h3, 1'b1);
      drain("post_rst");

      // Back-to-back frames
`ifdef MEDIAN_EDGE_REPLICATE_EN
      expw(4'h0, 4'h0, 4'h1, 1'b0);
      expw(4'h0, 4'h1, 4'h2, 1'b0);
      expw(4'h1, 4'h2, 4'h2, 1'b1);
      expw(4'hE, 4'hE, 4'hD, 1'b0);
      expw(4'hE, 4'hD, 4'hC, 1'b0);
      expw(4'hD, 4'hC, 4'hC, 1'b1);
`else
      expw(4'h0, 4'h1, 4'h2, 1'b1);
      expw(4'hE, 4'hD, 4'hC, 1'b1);
`endif
      send(4'h0, 1'b0);
      send(4'h1, 1'b0);
      send(4'h2, 1'b1);
      send(4'hE, 1'b0);
      send(4'hD, 1'b0);
      send(4'hC, 1'b1);
      drain("b2b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
